// File: rtl/shift_left32_iter.sv
// Iterative 32-bit logical left shifter (SLL/SLLI) for the RV32 execute stage.
// Shifts STEP bits per clock behind valid/ready handshakes on both sides.
module shift_left32_iter #(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inp,
  input  logic [4:0]  shamt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        busy
);

  if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : gen_step_check
    $error("shift_left32_iter: STEP must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] StepAmt = 5'(STEP);

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  remaining_q, remaining_d;
  logic [31:0] res_q, res_d;

  logic [4:0]  step_k;
  logic [4:0]  remaining_rest;
  logic [31:0] acc_shl;

  // Final step may be shorter than STEP; k never exceeds remaining, so no underflow.
  always_comb begin
    step_k         = (remaining_q < StepAmt) ? remaining_q : StepAmt;
    remaining_rest = remaining_q - step_k;
    acc_shl        = acc_q << step_k;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      remaining_q <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      res_q       <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = (shamt == 5'd0) ? StDone : StShift;
        end
      end
      StShift: begin
        if (remaining_rest == 5'd0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    remaining_d = remaining_q;
    res_d       = res_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d       = inp;
          remaining_d = shamt;
          if (shamt == 5'd0) begin
            res_d = inp;
          end
        end
      end
      StShift: begin
        acc_d       = acc_shl;
        remaining_d = remaining_rest;
        if (remaining_rest == 5'd0) begin
          res_d = acc_shl;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    res       = res_q;
  end

endmodule

// File: tb/tb_shift_left32_iter.sv
// Bench for shift_left32_iter: one instance per legal STEP, scoreboard of
// expected results and latencies, directed cases, async reset and random traffic.
module tb_shift_left32_iter;

  localparam int NDut = 5;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid_a  [NDut];
  logic        in_ready_a  [NDut];
  logic [31:0] inp_a       [NDut];
  logic [4:0]  shamt_a     [NDut];
  logic        out_valid_a [NDut];
  logic        out_ready_a [NDut];
  logic [31:0] res_a       [NDut];
  logic        busy_a      [NDut];

  int   steps [NDut] = '{1, 2, 4, 8, 16};
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  for (genvar g = 0; g < NDut; g++) begin : gen_dut
    shift_left32_iter #(
      .STEP(1 << g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid_a[g]),
      .in_ready (in_ready_a[g]),
      .inp      (inp_a[g]),
      .shamt    (shamt_a[g]),
      .out_valid(out_valid_a[g]),
      .out_ready(out_ready_a[g]),
      .res      (res_a[g]),
      .busy     (busy_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called on a negedge with the DUT idle; returns on a negedge with the DUT idle again.
  task automatic run_op(input int idx, input logic [31:0] a, input logic [4:0] s,
                        input int stall, input bit noise);
    exp_t e;
    exp_t got_e;
    int   edges;
    e.res = a << s;
    e.lat = 1 + (int'(s) + steps[idx] - 1) / steps[idx];
    check_eq("in_ready_idle", 32'(in_ready_a[idx]), 32'd1);
    in_valid_a[idx]  = 1'b1;
    inp_a[idx]       = a;
    shamt_a[idx]     = s;
    out_ready_a[idx] = (stall == 0);
    sb_q.push_back(e);
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    // Scramble operands after accept; they must not affect the op in flight.
    in_valid_a[idx] = 1'b0;
    inp_a[idx]      = $urandom;
    shamt_a[idx]    = 5'($urandom);
    while (!out_valid_a[idx] && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    if (sb_q.size() == 0) begin
      check_eq("sb_nonempty", 32'd0, 32'd1);
    end else begin
      got_e = sb_q.pop_front();
      check_eq("res", res_a[idx], got_e.res);
      check_eq("latency", 32'(edges), 32'(got_e.lat));
    end
    for (int i = 0; i < stall; i++) begin
      if (noise) begin
        in_valid_a[idx] = (i % 2 == 0);
        inp_a[idx]      = $urandom;
        shamt_a[idx]    = 5'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      check_eq("stall_out_valid", 32'(out_valid_a[idx]), 32'd1);
      check_eq("stall_res", res_a[idx], e.res);
      if (noise) begin
        check_eq("stall_in_ready", 32'(in_ready_a[idx]), 32'd0);
        check_eq("stall_busy", 32'(busy_a[idx]), 32'd1);
      end
    end
    in_valid_a[idx]  = 1'b0;
    out_ready_a[idx] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("out_valid_drop", 32'(out_valid_a[idx]), 32'd0);
    check_eq("in_ready_back", 32'(in_ready_a[idx]), 32'd1);
    check_eq("busy_clear", 32'(busy_a[idx]), 32'd0);
    out_ready_a[idx] = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NDut; i++) begin
      in_valid_a[i]  = 1'b0;
      inp_a[i]       = '0;
      shamt_a[i]     = '0;
      out_ready_a[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check_eq("rst_busy", 32'(busy_a[0]), 32'd0);
    check_eq("rst_res", res_a[0], 32'd0);
    check_eq("rst_res_s16", res_a[4], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(in_ready_a[0]), 32'd1);

    // Directed cases: STEP=1 is idx 0, STEP=4 is idx 2.
    run_op(0, 32'd150, 5'd2, 0, 1'b0);
    run_op(0, 32'hFFFF_FFF3, 5'd3, 0, 1'b0);
    run_op(0, 32'hDEAD_BEEF, 5'd0, 0, 1'b0);
    run_op(0, 32'd1, 5'd31, 0, 1'b0);
    run_op(2, 32'd1, 5'd31, 0, 1'b0);
    run_op(2, 32'd127, 5'd5, 0, 1'b0);
    run_op(0, 32'd92, 5'd4, 5, 1'b1);

    // Async reset mid-shift.
    in_valid_a[0]  = 1'b1;
    inp_a[0]       = 32'hFFFF_FFFF;
    shamt_a[0]     = 5'd20;
    out_ready_a[0] = 1'b0;
    @(posedge clk);
    #1 in_valid_a[0] = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    check_eq("pre_rst_busy", 32'(busy_a[0]), 32'd1);
    check_eq("pre_rst_res", res_a[0], 32'd1472);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_out_valid", 32'(out_valid_a[0]), 32'd0);
    check_eq("async_rst_busy", 32'(busy_a[0]), 32'd0);
    check_eq("async_rst_res", res_a[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rerst_in_ready", 32'(in_ready_a[0]), 32'd1);
    run_op(0, 32'd150, 5'd2, 0, 1'b0);

    // Random regression per STEP with occasional output stalls.
    for (int d = 0; d < NDut; d++) begin
      for (int n = 0; n < 1000; n++) begin
        int stall;
        stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        run_op(d, $urandom, 5'($urandom_range(0, 31)), stall, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_left32_iter.md
Name: shift_left32_iter

Overview:
Iterative 32-bit logical left shifter (SLL/SLLI) for the RV32 execute stage. It is the left-direction counterpart to the combinational right shifter. It trades latency for area by shifting STEP bits per clock. It uses valid/ready handshakes on both sides, so the multi-cycle ALU sequencer can stall on it.

Parameters:
STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4, 8, 16; any other value is a synthesis-time error.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept an operand
inp  input  32  value to shift
shamt  input  5  shift amount, unsigned, 0..31
out_valid  output  1  res holds a completed result
out_ready  input  1  consumer accepts the result
res  output  32  inp << shamt, zero-filled from the LSB
busy  output  1  high whenever state != IDLE

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low. Both are fixed.
- Reset, applied at any time including mid-shift: state=IDLE, acc=0, remaining=0, res=0, out_valid=0, busy=0. in_ready=1 from the first edge after deassert.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: acc<=inp, remaining<=shamt. Next state is SHIFT if shamt!=0; if shamt==0, res<=inp and next state is DONE.
  - SHIFT: each edge, k=min(STEP,remaining); acc<=acc<<k with zero fill; remaining<=remaining-k. On the edge where remaining-k==0: res<=acc<<k, next state is DONE.
  - DONE: out_valid=1, res stable. On out_valid&&out_ready, next state is IDLE and out_valid drops the following cycle.
- in_ready is high only in IDLE; there is no accept/complete overlap. in_valid is ignored in SHIFT and DONE.
- inp and shamt are sampled only on the accept edge; later changes have no effect on the operation in flight.
- Latency from the accept edge to out_valid high is 1+ceil(shamt/STEP) edges:
  - shamt=0: 1 edge.
  - STEP=1, shamt=31: 32 edges.
- Throughput: one result every latency+1 cycles when out_ready is held high.
- Arithmetic:
  - Pure logical shift. The sign of inp is irrelevant; bits shifted past bit 31 are discarded.
  - shamt is 5 bits, so amounts >=32 cannot occur.
  - remaining is 5 bits and never underflows, because k<=remaining.
- res is a registered output. It keeps its last value after the handshake and in IDLE, and is meaningful only while out_valid=1.
- busy = (state != IDLE); it is high in both SHIFT and DONE.
- There is no illegal state; any unreachable encoding returns to IDLE on the next edge.

Test Plan:
- STEP=1, inp=150, shamt=2, out_ready=1 -> res=600 (0x258); out_valid rises 3 edges after accept and is high for 1 cycle; in_ready returns to 1 on the next cycle.
- STEP=1, inp=-13 (0xFFFFFFF3), shamt=3 -> res=0xFFFFFF98 (-104); shamt=0 with inp=0xDEADBEEF -> res=0xDEADBEEF after 1 edge.
- inp=1, shamt=31: STEP=1 -> res=0x80000000 after 32 edges; STEP=4 -> same res after 9 edges. inp=127, shamt=5, STEP=4 -> res=0xFE0 after 3 edges (steps of 4 then 1).
- Backpressure: complete 92<<4 (res=1472) with out_ready=0 for 5 cycles, while toggling in_valid with new operands -> res stays 1472, out_valid=1, in_ready=0, busy=1. Raise out_ready -> one handshake, then IDLE; the queued operands are not captured.
- Reset mid-SHIFT: STEP=1, inp=0xFFFFFFFF, shamt=20, assert rst_n=0 at accept+5 edges, asynchronously between edges -> out_valid, busy and res go to 0 immediately without waiting for a clock. After release, in_ready=1 and a fresh 150<<2 returns 600 with normal latency.
- Random regression, 1000 operations for each legal STEP, with random out_ready stalls -> every res equals inp<<shamt, and every latency equals 1+ceil(shamt/STEP).
